// File: rtl/pulse_replay_pkg.sv
// Shared types and helpers for the multi-channel pulse replay block.
package pulse_replay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        GAP
    } state_t;

    // Bits needed for one timer that can count to the longest phase.
    function automatic int unsigned timer_width(input int unsigned delay_cyc,
                                                input int unsigned width_cyc,
                                                input int unsigned gap_cyc);
        int unsigned longest;
        longest = delay_cyc;
        if (width_cyc > longest) longest = width_cyc;
        if (gap_cyc > longest) longest = gap_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pulse_replay_edge_sync.sv
// Two-flop synchroniser followed by a registered one-cycle rising-edge strobe.
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q, rise_q;

    // prev_q resets low, so an input already high at reset release counts as a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pulse_replay.sv
// Per-channel capture of rising edges into a saturating queue, each replayed
// as a delayed, fixed-width output pulse followed by a forced low gap.
module pulse_replay
    import pulse_replay_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DELAY_CYC = 100_000_000,
    parameter int unsigned WIDTH_CYC = 100_000_000,
    parameter int unsigned GAP_CYC   = 50_000_000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH-1:0]         pulse_in,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         overflow,
    output logic [N_CH*CNT_W-1:0]   pending
);

    localparam int unsigned TW       = timer_width(DELAY_CYC, WIDTH_CYC, GAP_CYC);
    localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
    localparam logic [TW-1:0] D_LAST = TW'(DELAY_CYC - 1);
    localparam logic [TW-1:0] W_LAST = TW'(WIDTH_CYC - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             det_raw, det, done;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             ovf_q, ovf_d;
        logic [TW-1:0]    timer_q;
        logic             out_q;
        state_t           state_q;

        edge_sync u_sync (
            .clk_i  (clk),
            .rst_ni (reset),
            .d_i    (pulse_in[i]),
            .rise_o (det_raw)
        );

        assign det  = det_raw & enable[i];
        assign done = (state_q == HIGH) && (timer_q == W_LAST);

        // A capture and a completion in the same cycle cancel without touching overflow.
        always_comb begin
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (det && !done) begin
                if (pend_q == '1) ovf_d = 1'b1;
                else              pend_d = pend_q + 1'b1;
            end else if (done && !det) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                timer_q <= '0;
                out_q   <= 1'b0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else if (clear) begin
                state_q <= IDLE;
                timer_q <= '0;
                out_q   <= 1'b0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
                case (state_q)
                    IDLE: begin
                        if (pend_q != '0) begin
                            state_q <= DELAY;
                            timer_q <= '0;
                        end
                    end
                    DELAY: begin
                        if (timer_q == D_LAST) begin
                            state_q <= HIGH;
                            timer_q <= '0;
                            out_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (done) begin
                            out_q   <= 1'b0;
                            timer_q <= '0;
                            // With no gap phase, decide on the post-decrement queue depth here.
                            if (GAP_CYC != 0)        state_q <= GAP;
                            else if (pend_d != '0)   state_q <= DELAY;
                            else                     state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (timer_q == G_LAST) begin
                            timer_q <= '0;
                            state_q <= (pend_q != '0) ? DELAY : IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign pulse_out[i]                 = out_q;
        assign busy[i]                      = (state_q != IDLE);
        assign overflow[i]                  = ovf_q;
        assign pending[i*CNT_W +: CNT_W]    = pend_q;
    end

endmodule
